cordic_sequencer: RTL and testbench
===================================

# cordic_sequencer

Iterative CORDIC controller for the wave generator. It accepts one phase word, runs quadrant convergence, then time-multiplexes a single micro-rotation stage over N_ITER iterations. It returns registered sine/cosine with a one-cycle valid strobe. It sits between the phase accumulator and the output shaping logic, and replaces an unrolled pipeline to save area.

## Interface
- N_FRAC, 7: fractional bits; data words are N_FRAC+1 bits signed; N_FRAC >= 7
- N_ITER, 6: micro-rotation iterations, 1..8
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- z_i  in  N_FRAC+1  signed phase; full scale ±1.0 = ±pi; 0x40 = +pi/2, 0xC0 = -pi/2, 0x80 = -pi
- start_strobe_i  in  1  one-cycle request; z_i is sampled on the same edge
- busy_o  out  1  high while a computation is in flight
- cos_o  out  N_FRAC+1  signed cosine, Q1.N_FRAC
- sin_o  out  N_FRAC+1  signed sine, Q1.N_FRAC
- data_out_valid_strobe_o  out  1  one-cycle pulse; cos_o/sin_o are valid and held until the next result

## Operation
- FSM states:
  - IDLE: default state.
  - ITER: entered when a start is accepted; returns to IDLE after the last iteration.
- Iteration counter i: width 3, 0..N_ITER-1.
- Internal x, y: N_FRAC+2 bits, which gives one guard bit. Internal z: N_FRAC+1 bits.
- Start acceptance (state IDLE and start_strobe_i = 1), the load:
  - x = K, y = 0, z = z_i, where K = round(0.60725 * 2^N_FRAC); K = 78 at N_FRAC = 7.
  - If z_i > 0x40: x = 0, y = +K, z = z_i - 0x40.
  - Else if z_i < 0xC0: x = 0, y = -K, z = z_i + 0x40.
  - z_i = 0x80 therefore loads y = -K, z = 0xC0.
  - Then i = 0 and the FSM moves to ITER.
- ITER, each cycle:
  - d = +1 if z >= 0, else -1.
  - x' = x - d*(y >>> i)
  - y' = y + d*(x >>> i)
  - z' = z - d*ATAN[i]
  - Shifts are arithmetic. Addition wraps at internal width.
- ATAN[i] (N_FRAC = 7), i = 0..7: 32, 19, 10, 5, 3, 1, 1, 0. For N_FRAC > 7 the entries are scaled by << (N_FRAC-7).
- At i = N_ITER-1:
  - cos_o <= out(x'), sin_o <= out(y').
  - Strobe is asserted and the FSM returns to IDLE.
- start_strobe_i while in ITER is ignored, not queued.
- start_strobe_i is accepted in the cycle in which data_out_valid_strobe_o is high, because the FSM is already in IDLE.
- busy_o = (state == ITER).

## Timing
- Reset values: state IDLE, i = 0, x = y = z = 0, cos_o = sin_o = 0, busy_o = 0, data_out_valid_strobe_o = 0.
- rst_i has priority over everything, including start_strobe_i on the same edge.
- Reset mid-ITER discards the computation and no strobe is produced.
- Start sampled at edge E0. Iterations execute on edges E1..E_N_ITER.
- Outputs and strobe update at edge E_N_ITER, so latency from the sampling edge to the strobe is N_ITER cycles.
- busy_o is high for exactly N_ITER-1... corrected: busy_o is high from after E0 through E_N_ITER, i.e. N_ITER cycles, and low in the strobe cycle.
- Back-to-back period: N_ITER+1 cycles per result.
- Strobe is never high for two consecutive cycles.

## Configuration
- CORDIC_SATURATION_EN defined: out(v) clamps v to [-(2^N_FRAC-1), 2^N_FRAC-1]; 127/-127 at N_FRAC = 7.
- CORDIC_SATURATION_EN undefined: out(v) = v[N_FRAC:0], a plain truncation that wraps. For example, internal 128 appears as -128.
- Nothing else changes between the two builds.

## Test plan
- Default params, saturation on. z_i = 0x00 -> strobe 6 cycles after the start edge; cos_o = 127, |sin_o| <= 3.
- z_i = 0x40 -> |cos_o| <= 3, sin_o >= 124.
- z_i = 0x80 (-pi) -> cos_o <= -124, |sin_o| <= 3.
- z_i = 0x20 (pi/4) -> cos_o and sin_o each in 88..93.
- Start at cycle 0, second start at cycle 3 (busy): that start is ignored and exactly one strobe occurs at cycle 6. Third start in the strobe cycle -> accepted, next strobe at cycle 13.
- rst_i pulse at iteration 3 -> no strobe, all outputs 0, busy_o = 0 next cycle. Same test with the macro undefined and z_i = 0x00 -> cos_o = -128 (wrap), confirming the configuration.

Source files
------------

// File: rtl/cordic_sequencer.sv
// Iterative CORDIC sine/cosine: quadrant pre-rotation, then N_ITER micro-rotations on one shared stage.
// Optional output clamping is enabled by defining CORDIC_SATURATION_EN; otherwise results truncate and wrap.
module cordic_sequencer #(
  parameter int N_FRAC = 7,
  parameter int N_ITER = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic signed [N_FRAC:0]   z_i,
  input  logic                     start_strobe_i,
  output logic                     busy_o,
  output logic signed [N_FRAC:0]   cos_o,
  output logic signed [N_FRAC:0]   sin_o,
  output logic                     data_out_valid_strobe_o
);

  localparam int DW = N_FRAC + 1;
  localparam int IW = N_FRAC + 2;
  localparam int K_INT = $rtoi(0.60725 * (2.0 ** N_FRAC) + 0.5);
  localparam logic signed [IW-1:0] K = IW'(K_INT);
  localparam logic signed [DW-1:0] QUARTER = DW'(1 << (N_FRAC - 1));
  localparam logic [2:0] LAST_ITER = 3'(N_ITER - 1);
`ifdef CORDIC_SATURATION_EN
  localparam logic signed [IW-1:0] MAXV = IW'((1 << N_FRAC) - 1);
  localparam logic signed [IW-1:0] MINV = -MAXV;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [2:0]            r_iter;
  logic signed [IW-1:0]  r_x;
  logic signed [IW-1:0]  r_y;
  logic signed [DW-1:0]  r_z;
  logic signed [DW-1:0]  r_cos;
  logic signed [DW-1:0]  r_sin;
  logic                  r_strobe;

  logic                  w_load;
  logic                  w_last;
  logic signed [IW-1:0]  w_loadX;
  logic signed [IW-1:0]  w_loadY;
  logic signed [DW-1:0]  w_loadZ;
  logic signed [IW-1:0]  w_xShift;
  logic signed [IW-1:0]  w_yShift;
  logic signed [DW-1:0]  w_atan;
  logic signed [IW-1:0]  w_nextX;
  logic signed [IW-1:0]  w_nextY;
  logic signed [DW-1:0]  w_nextZ;
  logic signed [DW-1:0]  w_cosOut;
  logic signed [DW-1:0]  w_sinOut;

  // Angle table in phase units (pi = 2^N_FRAC), scaled up for wider phase words.
  function automatic logic signed [DW-1:0] atanEntry(input logic [2:0] idx);
    logic [DW-1:0] base;
    case (idx)
      3'd0:    base = DW'(32);
      3'd1:    base = DW'(19);
      3'd2:    base = DW'(10);
      3'd3:    base = DW'(5);
      3'd4:    base = DW'(3);
      3'd5:    base = DW'(1);
      3'd6:    base = DW'(1);
      default: base = DW'(0);
    endcase
    return base << (N_FRAC - 7);
  endfunction

  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_strobe_i) begin
          w_nextState = ITER;
          w_load      = 1'b1;
        end
      end
      ITER: begin
        if (r_iter == LAST_ITER) begin
          w_nextState = IDLE;
          w_last      = 1'b1;
        end
      end
    endcase
  end

  // Pre-rotate by +/-pi/2 so the remaining angle lies inside the CORDIC convergence range.
  always_comb begin
    w_loadX = K;
    w_loadY = '0;
    w_loadZ = z_i;
    if (z_i > QUARTER) begin
      w_loadX = '0;
      w_loadY = K;
      w_loadZ = z_i - QUARTER;
    end else if (z_i < -QUARTER) begin
      w_loadX = '0;
      w_loadY = -K;
      w_loadZ = z_i + QUARTER;
    end
  end

  always_comb begin
    w_xShift = r_x >>> r_iter;
    w_yShift = r_y >>> r_iter;
    w_atan   = atanEntry(r_iter);
    if (!r_z[DW-1]) begin
      w_nextX = r_x - w_yShift;
      w_nextY = r_y + w_xShift;
      w_nextZ = r_z - w_atan;
    end else begin
      w_nextX = r_x + w_yShift;
      w_nextY = r_y - w_xShift;
      w_nextZ = r_z + w_atan;
    end
  end

  always_comb begin
`ifdef CORDIC_SATURATION_EN
    w_cosOut = w_nextX[DW-1:0];
    w_sinOut = w_nextY[DW-1:0];
    if (w_nextX > MAXV)      w_cosOut = MAXV[DW-1:0];
    else if (w_nextX < MINV) w_cosOut = MINV[DW-1:0];
    if (w_nextY > MAXV)      w_sinOut = MAXV[DW-1:0];
    else if (w_nextY < MINV) w_sinOut = MINV[DW-1:0];
`else
    w_cosOut = w_nextX[DW-1:0];
    w_sinOut = w_nextY[DW-1:0];
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_iter   <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_cos    <= '0;
      r_sin    <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_strobe <= w_last;
      if (w_load) begin
        r_x    <= w_loadX;
        r_y    <= w_loadY;
        r_z    <= w_loadZ;
        r_iter <= '0;
      end else if (r_state == ITER) begin
        r_x    <= w_nextX;
        r_y    <= w_nextY;
        r_z    <= w_nextZ;
        r_iter <= w_last ? 3'd0 : r_iter + 3'd1;
      end
      if (w_last) begin
        r_cos <= w_cosOut;
        r_sin <= w_sinOut;
      end
    end
  end

  assign busy_o                  = (r_state == ITER);
  assign cos_o                   = r_cos;
  assign sin_o                   = r_sin;
  assign data_out_valid_strobe_o = r_strobe;

endmodule

// File: tb/tb_cordic_sequencer.sv
// Self-checking bench for cordic_sequencer: random and directed phases against an integer reference model.
module tb_cordic_sequencer;

  localparam int N_FRAC  = 7;
  localparam int N_ITER  = 6;
  localparam int TIMEOUT = 20;
  localparam int ATAN_TABLE [8] = '{32, 19, 10, 5, 3, 1, 1, 0};

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic signed [N_FRAC:0] z_i;
  logic                   start_strobe_i;
  logic                   busy_o;
  logic signed [N_FRAC:0] cos_o;
  logic signed [N_FRAC:0] sin_o;
  logic                   data_out_valid_strobe_o;

  int compareCount  = 0;
  int mismatchCount = 0;

  cordic_sequencer #(.N_FRAC(N_FRAC), .N_ITER(N_ITER)) dut (
    .clk_i                   (clk_i),
    .rst_i                   (rst_i),
    .z_i                     (z_i),
    .start_strobe_i          (start_strobe_i),
    .busy_o                  (busy_o),
    .cos_o                   (cos_o),
    .sin_o                   (sin_o),
    .data_out_valid_strobe_o (data_out_valid_strobe_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reduce an integer to a two's-complement value of the given bit width.
  function automatic int wrapTo(input int v, input int bits);
    int m;
    int r;
    m = 1 << bits;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  function automatic int outValue(input int v);
`ifdef CORDIC_SATURATION_EN
    int lim;
    lim = (1 << N_FRAC) - 1;
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
`else
    return wrapTo(v, N_FRAC + 1);
`endif
  endfunction

  // Rotation of (K, 0) through angle zIn, from the algorithm's arithmetic rules.
  function automatic void refModel(input int zIn, output int cosE, output int sinE);
    int x, y, z, nx, ny, d;
    int k;
    int quarter;
    k       = 78;
    quarter = 1 << (N_FRAC - 1);
    x = k;
    y = 0;
    z = zIn;
    if (zIn > quarter) begin
      x = 0; y = k; z = zIn - quarter;
    end else if (zIn < -quarter) begin
      x = 0; y = -k; z = zIn + quarter;
    end
    for (int i = 0; i < N_ITER; i++) begin
      d  = (z >= 0) ? 1 : -1;
      nx = wrapTo(x - d * (y >>> i), N_FRAC + 2);
      ny = wrapTo(y + d * (x >>> i), N_FRAC + 2);
      z  = wrapTo(z - d * ATAN_TABLE[i], N_FRAC + 1);
      x  = nx;
      y  = ny;
    end
    cosE = outValue(x);
    sinE = outValue(y);
  endfunction

  task automatic applyStimulus(input logic signed [N_FRAC:0] zVal);
    z_i            = zVal;
    start_strobe_i = 1'b1;
    @(negedge clk_i);
    start_strobe_i = 1'b0;
  endtask

  task automatic runOne(input logic signed [N_FRAC:0] zVal);
    int cosE, sinE, cycles;
    refModel(zVal, cosE, sinE);
    applyStimulus(zVal);
    checkOutput($sformatf("busyAfterStart z=%0d", zVal), busy_o, 1);
    cycles = 0;
    while (!data_out_valid_strobe_o && cycles < TIMEOUT) begin
      @(negedge clk_i);
      cycles++;
    end
    checkOutput($sformatf("latency z=%0d", zVal), cycles, N_ITER);
    checkOutput($sformatf("busyInStrobe z=%0d", zVal), busy_o, 0);
    checkOutput($sformatf("cos z=%0d", zVal), cos_o, cosE);
    checkOutput($sformatf("sin z=%0d", zVal), sin_o, sinE);
    @(negedge clk_i);
    checkOutput($sformatf("strobeDrop z=%0d", zVal), data_out_valid_strobe_o, 0);
    checkOutput($sformatf("cosHeld z=%0d", zVal), cos_o, cosE);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic signed [N_FRAC:0] directed [10];
    int cosA, sinA, cosC, sinC;
    int strobeCount, firstAt, secondAt;
    int cap1Cos, cap1Sin, cap2Cos, cap2Sin;

    directed = '{8'sh00, 8'sh40, 8'sh41, 8'sh80, 8'shC0, 8'shBF, 8'sh7F, 8'sh20, 8'shE0, 8'sh3F};

    rst_i          = 1'b1;
    start_strobe_i = 1'b0;
    z_i            = '0;
    repeat (3) @(negedge clk_i);
    checkOutput("resetBusy", busy_o, 0);
    checkOutput("resetStrobe", data_out_valid_strobe_o, 0);
    checkOutput("resetCos", cos_o, 0);
    checkOutput("resetSin", sin_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    runOne(8'sh00);
`ifdef CORDIC_SATURATION_EN
    checkOutput("cosZeroBuild", cos_o, 127);
`else
    checkOutput("cosZeroBuild", cos_o, -128);
`endif
    checkOutput("sinZeroSmall", (sin_o >= -3 && sin_o <= 3) ? 1 : 0, 1);

    runOne(8'sh20);
    checkOutput("cosPi4Range", (cos_o >= 88 && cos_o <= 93) ? 1 : 0, 1);
    checkOutput("sinPi4Range", (sin_o >= 88 && sin_o <= 93) ? 1 : 0, 1);

    foreach (directed[j]) runOne(directed[j]);

    for (int n = 0; n < 40; n++) runOne(8'($urandom_range(0, 255)));

    // Start during busy is dropped; start in the strobe cycle is accepted.
    refModel(-56, cosA, sinA);
    refModel(100, cosC, sinC);
    strobeCount = 0;
    firstAt     = -1;
    secondAt    = -1;
    cap1Cos = 0; cap1Sin = 0; cap2Cos = 0; cap2Sin = 0;
    for (int c = 0; c <= 16; c++) begin
      start_strobe_i = (c == 0 || c == 3 || c == 7);
      z_i = (c == 0) ? -8'sd56 : (c == 3) ? 8'sd17 : 8'sd100;
      if (c == 7) checkOutput("strobeWhenRestart", data_out_valid_strobe_o, 1);
      @(negedge clk_i);
      if (data_out_valid_strobe_o) begin
        strobeCount++;
        if (strobeCount == 1) begin
          firstAt = c; cap1Cos = cos_o; cap1Sin = sin_o;
        end else if (strobeCount == 2) begin
          secondAt = c; cap2Cos = cos_o; cap2Sin = sin_o;
        end
      end
    end
    start_strobe_i = 1'b0;
    checkOutput("overlapStrobeCount", strobeCount, 2);
    checkOutput("overlapFirstAt", firstAt, 6);
    checkOutput("overlapSecondAt", secondAt, 13);
    checkOutput("overlapFirstCos", cap1Cos, cosA);
    checkOutput("overlapFirstSin", cap1Sin, sinA);
    checkOutput("overlapSecondCos", cap2Cos, cosC);
    checkOutput("overlapSecondSin", cap2Sin, sinC);

    // Reset in the middle of a computation discards it.
    applyStimulus(8'sh10);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("midResetBusy", busy_o, 0);
    checkOutput("midResetCos", cos_o, 0);
    checkOutput("midResetSin", sin_o, 0);
    checkOutput("midResetStrobe", data_out_valid_strobe_o, 0);
    strobeCount = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (data_out_valid_strobe_o) strobeCount++;
    end
    checkOutput("midResetNoStrobe", strobeCount, 0);

    // Reset wins over a simultaneous start.
    rst_i          = 1'b1;
    start_strobe_i = 1'b1;
    z_i            = 8'sh30;
    @(negedge clk_i);
    rst_i          = 1'b0;
    start_strobe_i = 1'b0;
    checkOutput("resetBeatsStartBusy", busy_o, 0);
    @(negedge clk_i);
    checkOutput("resetBeatsStartIdle", busy_o, 0);

    runOne(8'sh30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
